// File: rtl/hm_rx_mt.sv
// hm_rx_mt: multi-tag TRN completion receiver. Completion payload is written into
// per-tag regions of two dword banks (even/odd); each tag closes with its own status.
module hm_rx_mt #(
  parameter int TAG_W     = 2,
  parameter int DEPTH_W   = 9,
  parameter int TIMEOUT_W = 16,
  parameter int SWAP      = 1
) (
  input  logic                     trn_clk,
  input  logic                     sys_rst,
  input  logic                     arm_valid,
  input  logic [TAG_W-1:0]         arm_tag,
  input  logic [9:0]               arm_len,
  output logic [(1<<TAG_W)-1:0]    armed,
  output logic                     done_valid,
  output logic [TAG_W-1:0]         done_tag,
  output logic [1:0]               done_status,
  output logic [10:0]              done_dw,
  output logic [TAG_W+DEPTH_W-2:0] mem_l_addr,
  output logic [TAG_W+DEPTH_W-2:0] mem_h_addr,
  output logic [31:0]              mem_l_data,
  output logic [31:0]              mem_h_data,
  output logic                     mem_l_we,
  output logic                     mem_h_we,
  input  logic [63:0]              trn_rd,
  input  logic                     trn_rrem_n,
  input  logic                     trn_rsof_n,
  input  logic                     trn_reof_n,
  input  logic                     trn_rsrc_rdy_n,
  output logic                     trn_rdst_rdy_n,
  output logic                     trn_rnp_ok_n,
  output logic [31:0]              stat_trn_cpt_rx,
  output logic [15:0]              stat_unexp,
  output logic [1:0]               stat_state
);

  localparam int NB_TAGS = 1 << TAG_W;
  localparam int IW      = TAG_W + DEPTH_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR2 = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_IGN  = 2'd3;

  function automatic logic [31:0] fix_dw(input logic [31:0] d);
    if (SWAP != 0) begin
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
    end else begin
      return d;
    end
  endfunction

  logic [1:0]           state_r;
  logic [2:0]           status_r;
  logic [11:0]          bc_r;
  logic [9:0]           len_r;
  logic [1:0]           fmt_r;
  logic [TAG_W-1:0]     cur_tag_r;
  logic                 skip_r;

  logic [10:0]          tag_len_r [NB_TAGS];
  logic [10:0]          wptr_r    [NB_TAGS];
  logic [1:0]           err_r     [NB_TAGS];
  logic [TIMEOUT_W-1:0] tmo_r     [NB_TAGS];

  logic                 beat_s, sof_s, eof_s;
  logic [7:0]           hdr_tag_s;
  logic                 tag_ok_s;
  logic [12:0]          bc13_s, len13_s;

  logic [TAG_W-1:0]     tag_s;
  logic                 act_s, a_req_s, b_req_s, a_ok_s, b_ok_s, ovf_s;
  logic [10:0]          wp_s, ln_s, wp_a_s, wp_new_s;
  logic [1:0]           err_new_s, close_st_s;
  logic                 close_s;
  logic [IW-1:0]        idx_a_s, idx_b_s;
  logic [31:0]          dw_a_s, dw_b_s;
  logic                 l_we_s, h_we_s;
  logic [IW-2:0]        l_addr_s, h_addr_s;
  logic [31:0]          l_data_s, h_data_s;
  logic                 to_hit_s;
  logic [TAG_W-1:0]     to_tag_s;
  logic                 dn_s;
  logic [TAG_W-1:0]     dn_tag_s;
  logic [1:0]           dn_st_s;
  logic [10:0]          dn_dw_s;
  logic                 arm_ok_s;

  assign trn_rdst_rdy_n = 1'b0;
  assign trn_rnp_ok_n   = 1'b0;
  assign stat_state     = state_r;

  assign beat_s    = ~trn_rsrc_rdy_n;
  assign sof_s     = beat_s & ~trn_rsof_n;
  assign eof_s     = beat_s & ~trn_reof_n;
  assign hdr_tag_s = trn_rd[47:40];
  assign tag_ok_s  = ((hdr_tag_s >> TAG_W) == 8'd0) && armed[hdr_tag_s[TAG_W-1:0]];
  // byte_count 0 and length 0 both encode the maximum (4096 bytes / 1024 dwords)
  assign bc13_s    = (bc_r == 12'd0) ? 13'd4096 : {1'b0, bc_r};
  assign len13_s   = {(len_r == 10'd0), len_r, 2'b00};

  // Per-beat write indices, error update and close decision for the active tag
  always_comb begin
    tag_s   = cur_tag_r;
    act_s   = 1'b0;
    a_req_s = 1'b0;
    b_req_s = 1'b0;
    if (state_r == S_HDR2) begin
      tag_s   = hdr_tag_s[TAG_W-1:0];
      act_s   = beat_s && tag_ok_s;
      a_req_s = act_s && (status_r == 3'd0) && (fmt_r == 2'b10);
    end else if (state_r == S_DATA) begin
      act_s   = beat_s && armed[cur_tag_r];
      a_req_s = act_s && !skip_r;
      b_req_s = act_s && !skip_r && !(eof_s && trn_rrem_n);
    end else begin
      act_s   = 1'b0;
    end

    wp_s     = wptr_r[tag_s];
    ln_s     = tag_len_r[tag_s];
    a_ok_s   = a_req_s && (wp_s < ln_s);
    wp_a_s   = wp_s + {10'd0, a_ok_s};
    b_ok_s   = b_req_s && (wp_a_s < ln_s);
    wp_new_s = wp_a_s + {10'd0, b_ok_s};
    ovf_s    = (a_req_s && !a_ok_s) || (b_req_s && !b_ok_s);

    err_new_s = err_r[tag_s];
    if (act_s && (state_r == S_HDR2) && (status_r != 3'd0)) begin
      err_new_s = 2'b01;
    end else if (ovf_s && (err_r[tag_s] == 2'b00)) begin
      err_new_s = 2'b11;
    end else begin
      err_new_s = err_r[tag_s];
    end

    close_s    = act_s && eof_s && ((bc13_s == len13_s) || (err_new_s != 2'b00));
    close_st_s = (err_new_s != 2'b00) ? err_new_s :
                 ((wp_new_s != ln_s) ? 2'b11 : 2'b00);

    // consecutive indices alternate banks, so each bank takes at most one dword per beat
    idx_a_s  = {tag_s, wp_s[DEPTH_W-1:0]};
    idx_b_s  = {tag_s, wp_a_s[DEPTH_W-1:0]};
    dw_a_s   = fix_dw(trn_rd[31:0]);
    dw_b_s   = fix_dw(trn_rd[63:32]);
    l_we_s   = 1'b0;
    l_addr_s = idx_a_s[IW-1:1];
    l_data_s = dw_a_s;
    h_we_s   = 1'b0;
    h_addr_s = idx_a_s[IW-1:1];
    h_data_s = dw_a_s;
    if (a_ok_s && !wp_s[0]) begin
      l_we_s = 1'b1;
    end else if (b_ok_s && !wp_a_s[0]) begin
      l_we_s   = 1'b1;
      l_addr_s = idx_b_s[IW-1:1];
      l_data_s = dw_b_s;
    end else begin
      l_we_s = 1'b0;
    end
    if (a_ok_s && wp_s[0]) begin
      h_we_s = 1'b1;
    end else if (b_ok_s && wp_a_s[0]) begin
      h_we_s   = 1'b1;
      h_addr_s = idx_b_s[IW-1:1];
      h_data_s = dw_b_s;
    end else begin
      h_we_s = 1'b0;
    end
  end

  // Lowest-index pending timeout, then done arbitration and arm acceptance
  always_comb begin
    to_hit_s = 1'b0;
    to_tag_s = {TAG_W{1'b0}};
    for (int i = NB_TAGS - 1; i >= 0; i--) begin
      if (armed[i] && (tmo_r[i] == {TIMEOUT_W{1'b1}})) begin
        to_hit_s = 1'b1;
        to_tag_s = TAG_W'(i);
      end else begin
        to_hit_s = to_hit_s;
      end
    end
    dn_s     = close_s || to_hit_s;
    dn_tag_s = close_s ? tag_s : to_tag_s;
    dn_st_s  = close_s ? close_st_s : 2'b10;
    dn_dw_s  = close_s ? wp_new_s : wptr_r[to_tag_s];
    arm_ok_s = arm_valid && (!armed[arm_tag] || (dn_s && (dn_tag_s == arm_tag)));
  end

  // Per-tag bookkeeping: arm, write pointer, error, inactivity counter
  always_ff @(posedge trn_clk) begin
    if (sys_rst) begin
      armed <= {NB_TAGS{1'b0}};
      for (int i = 0; i < NB_TAGS; i++) begin
        tag_len_r[i] <= 11'd0;
        wptr_r[i]    <= 11'd0;
        err_r[i]     <= 2'b00;
        tmo_r[i]     <= {TIMEOUT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NB_TAGS; i++) begin
        if (armed[i] && (tmo_r[i] != {TIMEOUT_W{1'b1}})) begin
          tmo_r[i] <= tmo_r[i] + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
        if (act_s && (tag_s == TAG_W'(i))) begin
          tmo_r[i]  <= {TIMEOUT_W{1'b0}};
          wptr_r[i] <= wp_new_s;
          err_r[i]  <= err_new_s;
        end
        if (dn_s && (dn_tag_s == TAG_W'(i))) begin
          armed[i] <= 1'b0;
        end
        // a close in the same cycle has already freed the tag, so the arm wins
        if (arm_ok_s && (arm_tag == TAG_W'(i))) begin
          armed[i]     <= 1'b1;
          tag_len_r[i] <= {(arm_len == 10'd0), arm_len};
          wptr_r[i]    <= 11'd0;
          err_r[i]     <= 2'b00;
          tmo_r[i]     <= {TIMEOUT_W{1'b0}};
        end
      end
    end
  end

  // Receive FSM, statistics and registered memory/done outputs
  always_ff @(posedge trn_clk) begin
    if (sys_rst) begin
      state_r         <= S_IDLE;
      status_r        <= 3'd0;
      bc_r            <= 12'd0;
      len_r           <= 10'd0;
      fmt_r           <= 2'b00;
      cur_tag_r       <= {TAG_W{1'b0}};
      skip_r          <= 1'b0;
      stat_trn_cpt_rx <= 32'd0;
      stat_unexp      <= 16'd0;
      mem_l_we        <= 1'b0;
      mem_h_we        <= 1'b0;
      mem_l_addr      <= {(IW-1){1'b0}};
      mem_h_addr      <= {(IW-1){1'b0}};
      mem_l_data      <= 32'd0;
      mem_h_data      <= 32'd0;
      done_valid      <= 1'b0;
      done_tag        <= {TAG_W{1'b0}};
      done_status     <= 2'b00;
      done_dw         <= 11'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (sof_s) begin
            if (trn_rd[60:56] == 5'b01010) begin
              fmt_r    <= trn_rd[62:61];
              len_r    <= trn_rd[41:32];
              status_r <= trn_rd[15:13];
              bc_r     <= trn_rd[11:0];
              state_r  <= eof_s ? S_IDLE : S_HDR2;
            end else begin
              state_r  <= eof_s ? S_IDLE : S_IGN;
            end
          end else if (beat_s && !eof_s) begin
            // tail of a TLP whose start was not seen (e.g. reset mid-packet)
            state_r <= S_IGN;
          end
        end
        S_HDR2: begin
          if (beat_s) begin
            if (!tag_ok_s) begin
              if (stat_unexp != 16'hFFFF) begin
                stat_unexp <= stat_unexp + 16'd1;
              end
              state_r <= eof_s ? S_IDLE : S_IGN;
            end else begin
              cur_tag_r <= hdr_tag_s[TAG_W-1:0];
              skip_r    <= (status_r != 3'd0) || (fmt_r != 2'b10);
              state_r   <= eof_s ? S_IDLE : S_DATA;
            end
          end
        end
        S_DATA, S_IGN: begin
          if (eof_s) begin
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase

      if (eof_s) begin
        stat_trn_cpt_rx <= stat_trn_cpt_rx + 32'd1;
      end

      mem_l_we   <= l_we_s;
      mem_l_addr <= l_addr_s;
      mem_l_data <= l_data_s;
      mem_h_we   <= h_we_s;
      mem_h_addr <= h_addr_s;
      mem_h_data <= h_data_s;

      done_valid <= dn_s;
      if (dn_s) begin
        done_tag    <= dn_tag_s;
        done_status <= dn_st_s;
        done_dw     <= dn_dw_s;
      end
    end
  end

endmodule

// File: tb/tb_hm_rx_mt.sv
// Directed bench for hm_rx_mt: a beat table with per-cycle expectations, plus
// hand-written timeout and reset-mid-TLP sequences.
module tb_hm_rx_mt;

  localparam int TAG_W = 2, DEPTH_W = 9, TIMEOUT_W = 4;

  logic        trn_clk = 1'b0;
  logic        sys_rst;
  logic        arm_valid;
  logic [1:0]  arm_tag;
  logic [9:0]  arm_len;
  logic [3:0]  armed;
  logic        done_valid;
  logic [1:0]  done_tag, done_status;
  logic [10:0] done_dw;
  logic [9:0]  mem_l_addr, mem_h_addr;
  logic [31:0] mem_l_data, mem_h_data;
  logic        mem_l_we, mem_h_we;
  logic [63:0] trn_rd;
  logic        trn_rrem_n, trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n;
  logic        trn_rdst_rdy_n, trn_rnp_ok_n;
  logic [31:0] stat_trn_cpt_rx;
  logic [15:0] stat_unexp;
  logic [1:0]  stat_state;

  always #5 trn_clk = ~trn_clk;

  hm_rx_mt #(.TAG_W(TAG_W), .DEPTH_W(DEPTH_W), .TIMEOUT_W(TIMEOUT_W), .SWAP(1)) dut (
    .trn_clk(trn_clk), .sys_rst(sys_rst),
    .arm_valid(arm_valid), .arm_tag(arm_tag), .arm_len(arm_len), .armed(armed),
    .done_valid(done_valid), .done_tag(done_tag), .done_status(done_status), .done_dw(done_dw),
    .mem_l_addr(mem_l_addr), .mem_h_addr(mem_h_addr),
    .mem_l_data(mem_l_data), .mem_h_data(mem_h_data),
    .mem_l_we(mem_l_we), .mem_h_we(mem_h_we),
    .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n),
    .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
    .trn_rdst_rdy_n(trn_rdst_rdy_n), .trn_rnp_ok_n(trn_rnp_ok_n),
    .stat_trn_cpt_rx(stat_trn_cpt_rx), .stat_unexp(stat_unexp), .stat_state(stat_state)
  );

  typedef struct {
    logic        arm_v;  logic [1:0] atag;  logic [9:0] alen;
    logic        vld, sof, eof, rrem;       logic [63:0] rd;
    logic        lwe;    logic [9:0] laddr; logic [31:0] ldata;
    logic        hwe;    logic [9:0] haddr; logic [31:0] hdata;
    logic        dv;     logic [1:0] dtag;  logic [1:0] dst;  logic [10:0] ddw;
    logic [3:0]  armed;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // 3DW completion header beat: DW0 on [63:32], DW1 on [31:0]
  function automatic logic [63:0] h1(input logic [1:0] fmt, input logic [9:0] len,
                                     input logic [2:0] st, input logic [11:0] bc);
    return {1'b0, fmt, 5'b01010, 14'd0, len, 16'h0200, st, 1'b0, bc};
  endfunction

  function automatic logic [63:0] h2(input logic [7:0] tag, input logic [31:0] d0);
    return {16'h0100, tag, 8'h00, d0};
  endfunction

  function automatic logic [31:0] dt(input int k);
    return 32'hC0DE0000 + k;
  endfunction

  task automatic add(input logic av, input logic [1:0] at, input logic [9:0] al,
                     input logic vld, input logic sof, input logic eof, input logic rrem,
                     input logic [63:0] rd,
                     input logic lwe, input logic [9:0] la, input logic [31:0] ld,
                     input logic hwe, input logic [9:0] ha, input logic [31:0] hd,
                     input logic dv, input logic [1:0] dtg, input logic [1:0] ds,
                     input logic [10:0] dd, input logic [3:0] arm);
    vec_t v;
    v.arm_v = av;  v.atag = at;  v.alen = al;
    v.vld = vld;   v.sof = sof;  v.eof = eof;  v.rrem = rrem;  v.rd = rd;
    v.lwe = lwe;   v.laddr = la; v.ldata = ld;
    v.hwe = hwe;   v.haddr = ha; v.hdata = hd;
    v.dv = dv;     v.dtag = dtg; v.dst = ds;   v.ddw = dd;     v.armed = arm;
    vq.push_back(v);
  endtask

  task automatic beat(input logic vld, input logic sof, input logic eof,
                      input logic rrem, input logic [63:0] rd);
    trn_rsrc_rdy_n = ~vld;
    trn_rsof_n     = ~sof;
    trn_reof_n     = ~eof;
    trn_rrem_n     = rrem;
    trn_rd         = rd;
  endtask

  initial begin
    int n;
    logic got;

    sys_rst = 1'b1;  arm_valid = 1'b0;  arm_tag = 2'd0;  arm_len = 10'd0;
    beat(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    repeat (3) @(posedge trn_clk);
    #1;
    chk("rst armed", armed, 4'b0000);
    chk("rst done_valid", done_valid, 1'b0);
    chk("rst done_fields", {done_tag, done_status, done_dw}, 15'd0);
    chk("rst mem_we", {mem_l_we, mem_h_we}, 2'b00);
    chk("rst mem_addr_data", {mem_l_addr, mem_h_addr, mem_l_data, mem_h_data}, 84'd0);
    chk("rst stats", {stat_trn_cpt_rx, stat_unexp, stat_state}, 50'd0);
    chk("rst tied", {trn_rdst_rdy_n, trn_rnp_ok_n}, 2'b00);
    @(negedge trn_clk);
    sys_rst = 1'b0;

    // tag 1, len 8, one 8-dword completion
    add(1,1,8,   0,0,0,0, 64'd0,                    0,0,0,          0,0,0,          0,0,0,0, 4'b0010);
    add(0,0,0,   1,1,0,0, h1(2'b10,8,0,32),         0,0,0,          0,0,0,          0,0,0,0, 4'b0010);
    add(0,0,0,   1,0,0,0, h2(1,dt(0)),              1,256,sw(dt(0)),0,0,0,          0,0,0,0, 4'b0010);
    add(0,0,0,   1,0,0,0, {dt(2),dt(1)},            1,257,sw(dt(2)),1,256,sw(dt(1)),0,0,0,0, 4'b0010);
    add(0,0,0,   0,1,1,0, {dt(99),dt(98)},          0,0,0,          0,0,0,          0,0,0,0, 4'b0010);
    add(0,0,0,   1,0,0,0, {dt(4),dt(3)},            1,258,sw(dt(4)),1,257,sw(dt(3)),0,0,0,0, 4'b0010);
    add(0,0,0,   1,0,0,0, {dt(6),dt(5)},            1,259,sw(dt(6)),1,258,sw(dt(5)),0,0,0,0, 4'b0010);
    add(0,0,0,   1,0,1,1, {32'd0,dt(7)},            0,0,0,          1,259,sw(dt(7)),1,1,0,8, 4'b0000);
    // tags 0 and 2, len 4 each, two interleaved 2-dword completions per tag
    add(1,0,4,   0,0,0,0, 64'd0,                    0,0,0,          0,0,0,          0,0,0,0, 4'b0001);
    add(1,2,4,   0,0,0,0, 64'd0,                    0,0,0,          0,0,0,          0,0,0,0, 4'b0101);
    add(0,0,0,   1,1,0,0, h1(2'b10,2,0,16),         0,0,0,          0,0,0,          0,0,0,0, 4'b0101);
    add(0,0,0,   1,0,0,0, h2(0,dt(10)),             1,0,sw(dt(10)), 0,0,0,          0,0,0,0, 4'b0101);
    add(0,0,0,   1,0,1,1, {32'd0,dt(11)},           0,0,0,          1,0,sw(dt(11)), 0,0,0,0, 4'b0101);
    add(0,0,0,   1,1,0,0, h1(2'b10,2,0,16),         0,0,0,          0,0,0,          0,0,0,0, 4'b0101);
    add(0,0,0,   1,0,0,0, h2(2,dt(20)),             1,512,sw(dt(20)),0,0,0,         0,0,0,0, 4'b0101);
    add(0,0,0,   1,0,1,1, {32'd0,dt(21)},           0,0,0,          1,512,sw(dt(21)),0,0,0,0, 4'b0101);
    add(0,0,0,   1,1,0,0, h1(2'b10,2,0,8),          0,0,0,          0,0,0,          0,0,0,0, 4'b0101);
    add(0,0,0,   1,0,0,0, h2(0,dt(12)),             1,1,sw(dt(12)), 0,0,0,          0,0,0,0, 4'b0101);
    add(0,0,0,   1,0,1,1, {32'd0,dt(13)},           0,0,0,          1,1,sw(dt(13)), 1,0,0,4, 4'b0100);
    add(0,0,0,   1,1,0,0, h1(2'b10,2,0,8),          0,0,0,          0,0,0,          0,0,0,0, 4'b0100);
    add(0,0,0,   1,0,0,0, h2(2,dt(22)),             1,513,sw(dt(22)),0,0,0,         0,0,0,0, 4'b0100);
    add(0,0,0,   1,0,1,1, {32'd0,dt(23)},           0,0,0,          1,513,sw(dt(23)),1,2,0,4, 4'b0000);
    // tag 0: completion without data, completer status 001
    add(1,0,4,   0,0,0,0, 64'd0,                    0,0,0,          0,0,0,          0,0,0,0, 4'b0001);
    add(0,0,0,   1,1,0,0, h1(2'b00,0,3'b001,16),    0,0,0,          0,0,0,          0,0,0,0, 4'b0001);
    add(0,0,0,   1,0,1,0, h2(0,32'd0),              0,0,0,          0,0,0,          1,0,1,0, 4'b0000);
    // tag 1, len 4, 6 dwords sent: overflow; re-arm on an armed tag is ignored,
    // re-arm in the closing cycle is accepted (len 1)
    add(1,1,4,   0,0,0,0, 64'd0,                    0,0,0,          0,0,0,          0,0,0,0, 4'b0010);
    add(0,0,0,   1,1,0,0, h1(2'b10,6,0,24),         0,0,0,          0,0,0,          0,0,0,0, 4'b0010);
    add(0,0,0,   1,0,0,0, h2(1,dt(30)),             1,256,sw(dt(30)),0,0,0,         0,0,0,0, 4'b0010);
    add(1,1,8,   1,0,0,0, {dt(32),dt(31)},          1,257,sw(dt(32)),1,256,sw(dt(31)),0,0,0,0, 4'b0010);
    add(0,0,0,   1,0,0,0, {dt(34),dt(33)},          0,0,0,          1,257,sw(dt(33)),0,0,0,0, 4'b0010);
    add(1,1,1,   1,0,1,1, {32'd0,dt(35)},           0,0,0,          0,0,0,          1,1,3,4, 4'b0010);
    // unarmed tag 3: dropped
    add(0,0,0,   1,1,0,0, h1(2'b10,1,0,4),          0,0,0,          0,0,0,          0,0,0,0, 4'b0010);
    add(0,0,0,   1,0,1,0, h2(3,dt(40)),             0,0,0,          0,0,0,          0,0,0,0, 4'b0010);
    // the tag 1 re-armed with len 1 fills from index 0
    add(0,0,0,   1,1,0,0, h1(2'b10,1,0,4),          0,0,0,          0,0,0,          0,0,0,0, 4'b0010);
    add(0,0,0,   1,0,1,1, h2(1,dt(50)),             1,256,sw(dt(50)),0,0,0,         1,1,0,1, 4'b0000);

    foreach (vq[i]) begin
      @(negedge trn_clk);
      arm_valid = vq[i].arm_v;  arm_tag = vq[i].atag;  arm_len = vq[i].alen;
      beat(vq[i].vld, vq[i].sof, vq[i].eof, vq[i].rrem, vq[i].rd);
      @(posedge trn_clk);
      #1;
      chk($sformatf("v%0d l_we", i), mem_l_we, vq[i].lwe);
      if (vq[i].lwe) begin
        chk($sformatf("v%0d l_addr", i), mem_l_addr, vq[i].laddr);
        chk($sformatf("v%0d l_data", i), mem_l_data, vq[i].ldata);
      end
      chk($sformatf("v%0d h_we", i), mem_h_we, vq[i].hwe);
      if (vq[i].hwe) begin
        chk($sformatf("v%0d h_addr", i), mem_h_addr, vq[i].haddr);
        chk($sformatf("v%0d h_data", i), mem_h_data, vq[i].hdata);
      end
      chk($sformatf("v%0d done_valid", i), done_valid, vq[i].dv);
      if (vq[i].dv) begin
        chk($sformatf("v%0d done_tag", i), done_tag, vq[i].dtag);
        chk($sformatf("v%0d done_status", i), done_status, vq[i].dst);
        chk($sformatf("v%0d done_dw", i), done_dw, vq[i].ddw);
      end
      chk($sformatf("v%0d armed", i), armed, vq[i].armed);
    end
    @(negedge trn_clk);
    arm_valid = 1'b0;
    beat(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("tbl stat_unexp", stat_unexp, 16'd1);
    chk("tbl stat_cpt_rx", stat_trn_cpt_rx, 32'd9);
    chk("tbl stat_state", stat_state, 2'd0);

    // timeout: counter reaches all-ones 15 cycles after arming, done follows next cycle
    arm_valid = 1'b1;  arm_tag = 2'd2;  arm_len = 10'd4;
    @(posedge trn_clk);
    #1;
    arm_valid = 1'b0;
    chk("to armed", armed, 4'b0100);
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge trn_clk);
      #1;
      n++;
      if (done_valid) got = 1'b1;
    end
    chk("to cycles", n, 16);
    chk("to tag", done_tag, 2'd2);
    chk("to status", done_status, 2'b10);
    chk("to dw", done_dw, 11'd0);
    chk("to armed_clr", armed, 4'b0000);
    @(posedge trn_clk);
    #1;
    chk("to pulse_len", done_valid, 1'b0);
    @(negedge trn_clk);
    beat(1'b1, 1'b1, 1'b0, 1'b0, h1(2'b10,1,0,4));
    @(negedge trn_clk);
    beat(1'b1, 1'b0, 1'b1, 1'b1, h2(2,dt(60)));
    @(posedge trn_clk);
    #1;
    chk("late l_we", mem_l_we, 1'b0);
    chk("late done", done_valid, 1'b0);
    chk("late stat_unexp", stat_unexp, 16'd2);

    // reset in the middle of a completion
    @(negedge trn_clk);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    arm_valid = 1'b1;  arm_tag = 2'd1;  arm_len = 10'd4;
    @(negedge trn_clk);
    arm_valid = 1'b0;
    beat(1'b1, 1'b1, 1'b0, 1'b0, h1(2'b10,4,0,16));
    @(negedge trn_clk);
    beat(1'b1, 1'b0, 1'b0, 1'b0, h2(1,dt(70)));
    @(posedge trn_clk);
    #1;
    chk("mr pre_write", {mem_l_we, mem_l_addr}, {1'b1, 10'd256});
    @(negedge trn_clk);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    sys_rst = 1'b1;
    @(posedge trn_clk);
    #1;
    chk("mr armed", armed, 4'b0000);
    chk("mr stats", {stat_trn_cpt_rx, stat_unexp}, 48'd0);
    @(negedge trn_clk);
    sys_rst = 1'b0;
    beat(1'b1, 1'b0, 1'b0, 1'b0, {dt(72),dt(71)});
    @(posedge trn_clk);
    #1;
    chk("mr ign_state", stat_state, 2'd3);
    chk("mr ign_we", {mem_l_we, mem_h_we}, 2'b00);
    @(negedge trn_clk);
    beat(1'b1, 1'b0, 1'b1, 1'b1, {32'd0,dt(73)});
    @(posedge trn_clk);
    #1;
    chk("mr idle_state", stat_state, 2'd0);
    chk("mr eof_we", {mem_l_we, mem_h_we}, 2'b00);
    chk("mr eof_done", done_valid, 1'b0);
    chk("mr cpt_rx", stat_trn_cpt_rx, 32'd1);
    @(negedge trn_clk);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
